control_sequencer: RTL

- Hardwired control unit for the datapath; replaces hand-sequenced T-state stimulus with a synthesizable FSM.
- Fetches via PC/MAR/MDR and decodes IR[31:27].
- Emits one-hot register selects and datapath strobes per T-step for ALU, mul/div, unary, NOP and HALT classes.
- Parametrised in register count, opcode width and instruction-counter width; adds a memory-ready wait and run/stop control.

---
 rtl/cs_pkg.sv | 45 ++++
 rtl/reg_select_decoder.sv | 19 +
 rtl/control_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, T-state
// encoding, IR field positions and opcode classification helpers.
package cs_pkg;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_e;

  function automatic logic is_alu3(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Converts a 4-bit register index into a NUM_REGS-wide one-hot select and
// flags whether the index names an implemented register.
module reg_select_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                valid_o
);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = (idx_i == 4'(i));
    end
  end

  assign valid_o = ({1'b0, idx_i} < 5'(NUM_REGS));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch with memory-ready wait, decode of
// IR[31:27], Moore-decoded datapath strobes, run/stop and retire counting.
module control_sequencer
  import cs_pkg::*;
#(
  parameter int              NUM_REGS  = 16,
  parameter int              OP_W      = 5,
  parameter int              CNT_W     = 16,
  parameter logic [OP_W-1:0] INC_PC_OP = OP_W'(12)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                stop,
  input  logic                mem_ready,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                PCin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OP_W-1:0]     ALU_Control,
  output logic                run,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count
);

  state_e             state_q, state_d;
  logic               first_t1_q, first_t1_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               retire;

  logic [4:0]          opc;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic                ra_ok, rb_ok, rc_ok;
  logic                alu3, muldiv, unary, nop, halt, legal;

  assign opc = IR[OPC_MSB:OPC_LSB];

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_dec_ra (
    .idx_i(IR[RA_MSB:RA_LSB]), .onehot_o(ra_oh), .valid_o(ra_ok));
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_dec_rb (
    .idx_i(IR[RB_MSB:RB_LSB]), .onehot_o(rb_oh), .valid_o(rb_ok));
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_dec_rc (
    .idx_i(IR[RC_MSB:RC_LSB]), .onehot_o(rc_oh), .valid_o(rc_ok));

  assign alu3   = is_alu3(opc);
  assign muldiv = is_muldiv(opc);
  assign unary  = is_unary(opc);
  assign nop    = (opc == OP_NOP);
  assign halt   = (opc == OP_HALT);
  // Only the register fields an instruction class actually uses are range-checked.
  assign legal  = (alu3 && ra_ok && rb_ok && rc_ok) ||
                  ((muldiv || unary) && ra_ok && rb_ok) || nop || halt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      first_t1_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      first_t1_q <= first_t1_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    first_t1_d = 1'b0;
    retire     = 1'b0;
    case (state_q)
      IDLE: if (start && !stop) state_d = T0;
      T0: begin
        state_d    = T1;
        first_t1_d = 1'b1;
      end
      T1: if (mem_ready) state_d = T2;
      T2: state_d = T3;
      T3: begin
        if (!legal || nop) retire = 1'b1;
        else if (halt)     state_d = HALT;
        else               state_d = T4;
      end
      T4: if (unary) retire = 1'b1; else state_d = T5;
      T5: if (muldiv) state_d = T6; else retire = 1'b1;
      T6: retire = 1'b1;
      HALT: if (start) state_d = T0;
      default: state_d = IDLE;
    endcase
    if (retire) begin
      count_d = count_q + CNT_W'(1);
      state_d = stop ? IDLE : T0;
    end
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Read = 1'b0; illegal_op = 1'b0;
    Rin = '0; Rout = '0; ALU_Control = '0;
    case (state_q)
      T0: begin
        PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_Control = INC_PC_OP;
      end
      T1: begin
        // The incremented PC is loaded once even when T1 stretches for memory.
        Read = 1'b1; MDRin = 1'b1; Zlowout = first_t1_q; PCin = first_t1_q;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        if (!legal) illegal_op = 1'b1;
        else if (alu3)   begin Rout = rb_oh; Yin = 1'b1; end
        else if (muldiv) begin Rout = ra_oh; Yin = 1'b1; end
        else if (unary)  begin Rout = rb_oh; Zin = 1'b1; ALU_Control = OP_W'(opc); end
      end
      T4: begin
        if (alu3)        begin Rout = rc_oh; Zin = 1'b1; ALU_Control = OP_W'(opc); end
        else if (muldiv) begin Rout = rb_oh; Zin = 1'b1; ALU_Control = OP_W'(opc); end
        else if (unary)  begin Zlowout = 1'b1; Rin = ra_oh; end
      end
      T5: begin
        Zlowout = 1'b1;
        if (alu3)        Rin = ra_oh;
        else if (muldiv) LOin = 1'b1;
      end
      T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

  assign run         = (state_q != IDLE) && (state_q != HALT);
  assign instr_count = count_q;

endmodule
